// File: rtl/multicycle_control_unit.sv
// Main FSM of the multicycle CPU: decodes opcode/funct and drives datapath controls per state.
// Optional FPU support (FEXEC/FWAIT/FWB, lwc1/swc1 bank bits) is enabled by defining MCU_FPU_EN.
module multicycle_control_unit #(
   parameter int unsigned FPU_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       UBusy,
   input  logic       Rx_ready,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       ToggleEqual,
   output logic [1:0] PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] FPUControl,
   output logic       ALUorFPU,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ShiftD,
   output logic       Shift,
   output logic       BorL,
   output logic [2:0] RegConcat,
   output logic       Out,
   output logic       Tx_start,
   output logic [5:0] state
);

   typedef enum logic [5:0] {
      FETCH0 = 6'd0,  FETCH1 = 6'd1,  DECODE = 6'd2,  REXEC  = 6'd3,
      ALUWB  = 6'd4,  MEMADR = 6'd5,  MEMRD  = 6'd6,  MEMWAIT = 6'd7,
      MEMWB  = 6'd8,  MEMWR  = 6'd9,  BRANCH = 6'd10, IEXEC  = 6'd11,
      IWB    = 6'd12, LUI    = 6'd13, JUMP   = 6'd14, JAL    = 6'd15,
      JR     = 6'd16, FEXEC  = 6'd17, FWAIT  = 6'd18, FWB    = 6'd19,
      OUTLD  = 6'd20, OUTTX  = 6'd21, INWAIT = 6'd22, INWB   = 6'd23,
      HALT   = 6'd63
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // FWAIT spans FPU_LATENCY-1 cycles (at least one), counted 0..FWAIT_LAST
   localparam int unsigned FWAIT_LAST = (FPU_LATENCY > 1) ? FPU_LATENCY - 2 : 0;

   state_t      cur, nxt;
   logic [15:0] fcnt;

   always_ff @(posedge clk) begin
      if (rstn) begin
         cur  <= FETCH0;
         fcnt <= '0;
      end else begin
         cur  <= nxt;
         fcnt <= (cur == FWAIT) ? fcnt + 16'd1 : '0;
      end
   end

   assign state = cur;

   always_comb begin
      nxt         = cur;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      Branch      = 1'b0;
      ToggleEqual = 1'b0;
      PCSrc       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUControl  = ALU_AND;
      FPUControl  = 3'b000;
      ALUorFPU    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ShiftD      = 1'b0;
      Shift       = 1'b0;
      BorL        = 1'b0;
      RegConcat   = 3'b000;
      Out         = 1'b0;
      Tx_start    = 1'b0;

      // Outputs stay zero while reset is held so an aborted instruction cannot write
      if (!rstn) begin
         case (cur)
            FETCH0: nxt = FETCH1;
            FETCH1: begin
               IRWrite    = 1'b1;
               ALUSrcB    = 2'b01;
               ALUControl = ALU_ADD;
               PCWrite    = 1'b1;
               nxt        = DECODE;
            end
            DECODE: begin
               ALUSrcB    = 2'b11;
               ALUControl = ALU_ADD;
               case (opcode)
                  6'h00:         nxt = (funct == 6'h08) ? JR : REXEC;
                  6'h23, 6'h2B:  nxt = MEMADR;
`ifdef MCU_FPU_EN
                  6'h31, 6'h39:  nxt = MEMADR;
                  6'h11:         nxt = FEXEC;
`endif
                  6'h04, 6'h05:  nxt = BRANCH;
                  6'h08:         nxt = IEXEC;
                  6'h0F:         nxt = LUI;
                  6'h02:         nxt = JUMP;
                  6'h03:         nxt = JAL;
                  6'h3F:         nxt = OUTLD;
                  6'h3E:         nxt = INWAIT;
                  default:       nxt = HALT;
               endcase
            end
            REXEC: begin
               ALUSrcA = 1'b1;
               nxt     = ALUWB;
               case (funct)
                  6'h20: ALUControl = ALU_ADD;
                  6'h22: ALUControl = ALU_SUB;
                  6'h24: ALUControl = ALU_AND;
                  6'h25: ALUControl = ALU_OR;
                  6'h2A: ALUControl = ALU_SLT;
                  6'h00: begin Shift = 1'b1; ALUControl = ALU_OR; end
                  6'h02: begin Shift = 1'b1; ShiftD = 1'b1; ALUControl = ALU_OR; end
                  default: nxt = HALT;
               endcase
            end
            ALUWB: begin
               RegWrite = 1'b1;
               RegDst   = 2'b01;
               nxt      = FETCH0;
            end
            MEMADR: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               ALUControl = ALU_ADD;
               nxt        = (opcode == 6'h23 || opcode == 6'h31) ? MEMRD : MEMWR;
            end
            MEMRD:   begin IorD = 1'b1; nxt = MEMWAIT; end
            MEMWAIT: begin IorD = 1'b1; nxt = MEMWB; end
            MEMWB: begin
               RegWrite     = 1'b1;
               MemtoReg     = 2'b01;
               RegConcat[0] = (opcode == 6'h31);
               nxt          = FETCH0;
            end
            MEMWR: begin
               IorD         = 1'b1;
               MemWrite     = 1'b1;
               RegConcat[1] = (opcode == 6'h39);
               nxt          = FETCH0;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUControl  = ALU_SUB;
               Branch      = 1'b1;
               PCSrc       = 2'b01;
               ToggleEqual = (opcode == 6'h05);
               nxt         = FETCH0;
            end
            IEXEC: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               ALUControl = ALU_ADD;
               nxt        = IWB;
            end
            IWB: begin
               RegWrite = 1'b1;
               nxt      = FETCH0;
            end
            LUI: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b11;
               BorL       = 1'b1;
               ALUControl = ALU_OR;
               nxt        = IWB;
            end
            JUMP: begin
               PCSrc   = 2'b10;
               PCWrite = 1'b1;
               nxt     = FETCH0;
            end
            JAL: begin
               PCSrc    = 2'b10;
               PCWrite  = 1'b1;
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
               nxt      = FETCH0;
            end
            JR: begin
               ALUSrcA    = 1'b1;
               ALUControl = ALU_OR;
               PCWrite    = 1'b1;
               nxt        = FETCH0;
            end
            FEXEC, FWAIT: begin
               ALUSrcA    = 1'b1;
               RegConcat  = 3'b111;
               ALUorFPU   = 1'b1;
               FPUControl = funct[2:0];
               if (cur == FEXEC)
                  nxt = (funct > 6'h03) ? HALT : FWAIT;
               else if (32'(fcnt) >= FWAIT_LAST)
                  nxt = FWB;
            end
            FWB: begin
               ALUorFPU  = 1'b1;
               RegWrite  = 1'b1;
               RegDst    = 2'b01;
               RegConcat = 3'b111;
               nxt       = FETCH0;
            end
            OUTLD: begin
               Out = 1'b1;
               nxt = OUTTX;
            end
            OUTTX: begin
               if (!UBusy) begin
                  Tx_start = 1'b1;
                  nxt      = FETCH0;
               end
            end
            INWAIT: if (Rx_ready) nxt = INWB;
            INWB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b11;
               nxt      = FETCH0;
            end
            HALT:    nxt = HALT;
            default: nxt = HALT;
         endcase
      end

`ifndef MCU_FPU_EN
      FPUControl = 3'b000;
      ALUorFPU   = 1'b0;
      RegConcat  = 3'b000;
`endif
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; FPU steps run only when MCU_FPU_EN is defined.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rstn;
   logic [5:0] opcode, funct;
   logic       UBusy, Rx_ready;
   logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual;
   logic [1:0] PCSrc, ALUSrcB, RegDst, MemtoReg;
   logic       ALUSrcA, ALUorFPU, RegWrite, ShiftD, Shift, BorL, Out, Tx_start;
   logic [2:0] ALUControl, FPUControl, RegConcat;
   logic [5:0] state;

   int checks   = 0;
   int failures = 0;

   multicycle_control_unit #(.FPU_LATENCY(4)) dut (
      .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct),
      .UBusy(UBusy), .Rx_ready(Rx_ready),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .Branch(Branch), .ToggleEqual(ToggleEqual), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .FPUControl(FPUControl), .ALUorFPU(ALUorFPU), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .ShiftD(ShiftD), .Shift(Shift),
      .BorL(BorL), .RegConcat(RegConcat), .Out(Out), .Tx_start(Tx_start),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch_decode();
      chk("fetch0_state", state, 0);
      chk("fetch0_iord", IorD, 0);
      tick();
      chk("fetch1_state", state, 1);
      chk("fetch1_irwrite", IRWrite, 1);
      chk("fetch1_pcwrite", PCWrite, 1);
      chk("fetch1_srcb", ALUSrcB, 2'b01);
      chk("fetch1_alu", ALUControl, 3'b010);
      tick();
      chk("decode_state", state, 2);
      chk("decode_srcb", ALUSrcB, 2'b11);
      chk("decode_pcwrite", PCWrite, 0);
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      tick();
      tick();
      chk("reset_state", state, 0);
      chk("reset_outs", {IorD, MemWrite, IRWrite, PCWrite, RegWrite, Out, Tx_start}, 0);
      rstn = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; opcode = 6'h00; funct = 6'h20; UBusy = 1'b0; Rx_ready = 1'b0;
      do_reset();

      // R-type add
      fetch_decode();
      tick(); chk("radd_state", state, 3); chk("radd_alu", ALUControl, 3'b010);
      chk("radd_srca", ALUSrcA, 1);
      tick(); chk("aluwb_state", state, 4); chk("aluwb_regwrite", RegWrite, 1);
      chk("aluwb_regdst", RegDst, 2'b01); chk("aluwb_memtoreg", MemtoReg, 2'b00);
      tick(); chk("radd_done", state, 0);

      // R-type sub and sll
      funct = 6'h22;
      fetch_decode();
      tick(); chk("rsub_alu", ALUControl, 3'b110);
      tick(); tick();
      funct = 6'h00;
      fetch_decode();
      tick(); chk("sll_shift", {Shift, ShiftD}, 2'b10); chk("sll_alu", ALUControl, 3'b001);
      tick(); tick();

      // lw
      opcode = 6'h23;
      fetch_decode();
      tick(); chk("lw_memadr", state, 5); chk("lw_srcb", ALUSrcB, 2'b10);
      tick(); chk("lw_memrd", state, 6); chk("lw_iord6", IorD, 1);
      tick(); chk("lw_memwait", state, 7); chk("lw_iord7", IorD, 1);
      tick(); chk("lw_memwb", state, 8); chk("lw_memtoreg", MemtoReg, 2'b01);
      chk("lw_regwrite", RegWrite, 1); chk("lw_regdst", RegDst, 2'b00);
      chk("lw_regconcat", RegConcat, 0);
      tick(); chk("lw_done", state, 0);

      // sw
      opcode = 6'h2B;
      fetch_decode();
      tick(); chk("sw_memadr", state, 5); chk("sw_memwrite5", MemWrite, 0);
      tick(); chk("sw_memwr", state, 9); chk("sw_memwrite9", MemWrite, 1); chk("sw_iord", IorD, 1);
      tick(); chk("sw_done", state, 0); chk("sw_memwrite0", MemWrite, 0);

      // beq / bne
      opcode = 6'h04;
      fetch_decode();
      tick(); chk("beq_state", state, 10); chk("beq_branch", Branch, 1);
      chk("beq_toggle", ToggleEqual, 0); chk("beq_alu", ALUControl, 3'b110); chk("beq_pcsrc", PCSrc, 2'b01);
      tick();
      opcode = 6'h05;
      fetch_decode();
      tick(); chk("bne_state", state, 10); chk("bne_toggle", ToggleEqual, 1);
      tick();

      // addi, lui
      opcode = 6'h08;
      fetch_decode();
      tick(); chk("addi_state", state, 11); chk("addi_srcb", ALUSrcB, 2'b10);
      tick(); chk("iwb_state", state, 12); chk("iwb_regwrite", RegWrite, 1); chk("iwb_regdst", RegDst, 0);
      tick();
      opcode = 6'h0F;
      fetch_decode();
      tick(); chk("lui_state", state, 13); chk("lui_borl", BorL, 1); chk("lui_alu", ALUControl, 3'b001);
      chk("lui_srcb", ALUSrcB, 2'b11);
      tick(); chk("lui_iwb", state, 12);
      tick();

      // j, jal, jr
      opcode = 6'h02;
      fetch_decode();
      tick(); chk("j_state", state, 14); chk("j_pcsrc", PCSrc, 2'b10); chk("j_pcwrite", PCWrite, 1);
      chk("j_regwrite", RegWrite, 0);
      tick();
      opcode = 6'h03;
      fetch_decode();
      tick(); chk("jal_state", state, 15); chk("jal_regdst", RegDst, 2'b10);
      chk("jal_memtoreg", MemtoReg, 2'b10); chk("jal_regwrite", RegWrite, 1);
      tick();
      opcode = 6'h00; funct = 6'h08;
      fetch_decode();
      tick(); chk("jr_state", state, 16); chk("jr_pcsrc", PCSrc, 2'b00); chk("jr_pcwrite", PCWrite, 1);
      chk("jr_alu", ALUControl, 3'b001);
      tick(); chk("jr_done", state, 0);

      // out with UART busy for 5 cycles in OUTTX
      opcode = 6'h3F; UBusy = 1'b1;
      fetch_decode();
      tick(); chk("out_state", state, 20); chk("out_out", Out, 1); chk("out_tx20", Tx_start, 0);
      for (int i = 0; i < 5; i++) begin
         tick(); chk("outtx_wait_state", state, 21); chk("outtx_wait_tx", Tx_start, 0);
         chk("outtx_wait_out", Out, 0);
      end
      UBusy = 1'b0;
      #1; chk("outtx_tx", Tx_start, 1);
      tick(); chk("outtx_done", state, 0); chk("outtx_tx_off", Tx_start, 0);

      // in with Rx_ready after 10 cycles
      opcode = 6'h3E;
      fetch_decode();
      for (int i = 0; i < 10; i++) begin
         tick(); chk("inwait_state", state, 22); chk("inwait_regwrite", RegWrite, 0);
      end
      Rx_ready = 1'b1;
      tick(); Rx_ready = 1'b0;
      chk("inwb_state", state, 23); chk("inwb_memtoreg", MemtoReg, 2'b11); chk("inwb_regwrite", RegWrite, 1);
      tick(); chk("in_done", state, 0);

      // Reset aborts a load in MEMWB: RegWrite must drop immediately
      opcode = 6'h23;
      fetch_decode();
      tick(); tick(); tick(); tick();
      chk("abort_pre", RegWrite, 1);
      rstn = 1'b1; #1;
      chk("abort_regwrite", RegWrite, 0);
      tick(); chk("abort_state", state, 0); chk("abort_iord", IorD, 0);
      rstn = 1'b0;

      // Unknown R funct halts after REXEC
      opcode = 6'h00; funct = 6'h03;
      fetch_decode();
      tick(); chk("badfunct_rexec", state, 3);
      tick(); chk("badfunct_halt", state, 63);
      do_reset();

`ifdef MCU_FPU_EN
      // fmul: FEXEC + 3 FWAIT cycles hold FPUControl, then FWB
      opcode = 6'h11; funct = 6'h02;
      fetch_decode();
      tick(); chk("fexec_state", state, 17); chk("fexec_fpuctl", FPUControl, 3'b010);
      chk("fexec_aluorfpu", ALUorFPU, 1); chk("fexec_concat", RegConcat, 3'b111);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("fwait_state", state, 18); chk("fwait_fpuctl", FPUControl, 3'b010);
      end
      tick(); chk("fwb_state", state, 19); chk("fwb_concat", RegConcat, 3'b111);
      chk("fwb_regwrite", RegWrite, 1); chk("fwb_regdst", RegDst, 2'b01);
      tick(); chk("fpu_done", state, 0);
      opcode = 6'h31;
      fetch_decode();
      tick(); tick(); tick(); tick();
      chk("lwc1_memwb", state, 8); chk("lwc1_concat", RegConcat, 3'b001);
      tick();
`else
      // FPU opcodes halt when the FPU is not built in
      opcode = 6'h11; funct = 6'h02;
      fetch_decode();
      tick(); chk("nofpu_halt", state, 63); chk("nofpu_aluorfpu", ALUorFPU, 0);
      do_reset();
      opcode = 6'h31;
      fetch_decode();
      tick(); chk("nofpu_lwc1_halt", state, 63);
      do_reset();
`endif

      // Illegal opcode: HALT holds with all outputs zero until reset
      opcode = 6'h3A;
      fetch_decode();
      tick(); chk("halt_state", state, 63);
      tick(); tick();
      chk("halt_hold", state, 63);
      chk("halt_outs", {IorD, MemWrite, IRWrite, PCWrite, RegWrite, Out, Tx_start, Branch}, 0);
      do_reset();
      chk("halt_cleared", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
